axis_packet_gen: RTL
====================

Name: axis_packet_gen

Overview:
- Parametrised AXI-Stream packet generator that drives one mesh ingress port. It replaces hand-coded per-port stimulus with configurable traffic.
- Emits packets of programmable length, destination pattern and inter-packet gap.
- Payload is self-describing (source, sequence, beat index) so downstream checkers can verify ordering and integrity.
- Instantiated once per router port in mesh benches and on-chip traffic tests.

Parameters:
TDATA_WIDTH, 32, payload width; must be >= TDEST_WIDTH+SEQ_WIDTH+LEN_WIDTH
TDEST_WIDTH, 4, destination field width
NUM_DESTS, 4, number of valid destinations (endpoints 0..NUM_DESTS-1)
SRC_ID, 0, this generator's endpoint id
LEN_WIDTH, 8, packet-length field width (beats)
SEQ_WIDTH, 16, sequence-number / packet-counter width
GAP_WIDTH, 8, inter-packet gap field width (cycles)

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse; latches cfg_* and begins generation
cfg_stop  in  1  one-cycle pulse; request graceful stop
cfg_mode  in  2  dest mode: 0 fixed, 1 round-robin, 2 LFSR, 3 round-robin skipping SRC_ID
cfg_fixed_dest  in  TDEST_WIDTH  destination for mode 0
cfg_pkt_len  in  LEN_WIDTH  beats per packet; 0 treated as 1
cfg_num_pkts  in  SEQ_WIDTH  packets to send; 0 = unlimited
cfg_gap  in  GAP_WIDTH  idle cycles between packets
busy  out  1  generator active
done  out  1  one-cycle completion pulse
pkts_sent  out  SEQ_WIDTH  packets fully accepted since last start
axis_out_tvalid  out  1  AXIS valid
axis_out_tready  in  1  AXIS ready
axis_out_tdata  out  TDATA_WIDTH  payload
axis_out_tlast  out  1  last beat of packet
axis_out_tdest  out  TDEST_WIDTH  packet destination

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State = IDLE.
  - busy, done, tvalid and tlast = 0; tdata, tdest and pkts_sent = 0.
  - LFSR = 16'hACE1; round-robin pointer = 0; stop_pending = 0.
  - Reset mid-packet abandons the packet immediately. tvalid drops the cycle after reset is sampled.
- All outputs are registered.
- States:
  - IDLE: cfg_start=1 latches config, clears pkts_sent, computes first dest and enters SEND. tvalid=1 and busy=1 on the next cycle (latency 1). cfg_stop in IDLE is ignored. Start and stop in the same cycle: start wins, stop discarded.
  - SEND: presents beats. A beat is accepted when tvalid && tready. tdata, tdest and tlast are held stable while tvalid && !tready. tvalid never deasserts without a handshake. tlast=1 on beat cfg_pkt_len-1.
  - On the tlast handshake: pkts_sent++ (wraps at 2^SEQ_WIDTH). Then:
    - If cfg_num_pkts != 0 and pkts_sent reaches cfg_num_pkts, or stop_pending: go to IDLE, pulse done, busy=0 the next cycle.
    - Else if cfg_gap == 0: next packet's first beat is valid the next cycle (back-to-back).
    - Else go to GAP.
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND with the next dest. A stop pending or arriving in GAP goes to IDLE immediately with a done pulse.
- cfg_stop in SEND sets stop_pending (sticky). The current packet always completes; truncated packets are never emitted.
- cfg_start while busy is ignored.
- Payload per beat: tdata = {SRC_ID[TDEST_WIDTH-1:0], seq[SEQ_WIDTH-1:0], beat_idx}.
  - seq = pkts_sent value at packet start.
  - beat_idx fills the remaining low bits, counts 0..len-1, zero-extended.
- Dest update occurs once per packet, at packet start:
  - Mode 0: cfg_fixed_dest.
  - Mode 1: 0,1,..,NUM_DESTS-1, wrapping.
  - Mode 2: 16-bit Fibonacci LFSR, taps 16,14,13,11, advanced once per packet; dest = lfsr mod NUM_DESTS.
  - Mode 3: as mode 1, but skips SRC_ID. If NUM_DESTS==1, uses SRC_ID.
- Round-robin pointer and LFSR persist across starts; only reset clears them.

Test Plan:
- Mode 0, dest 3, len 4, num 2, gap 0, tready=1: start at cycle N gives 8 consecutive valid beats from N+1. tlast on beats 3 and 7. tdata seq 0 then 1, beat_idx 0..3. done pulses once and pkts_sent=2.
- Random tready backpressure, len 5, num 3: tdata, tdest and tlast stable while stalled; exactly 15 handshakes; no tvalid drop before a handshake.
- Mode 1, NUM_DESTS 4, num 6, gap 2: dests 0,1,2,3,0,1. Exactly 2 tvalid-low cycles between packets.
- Mode 3, SRC_ID 1, num 4: dests 0,2,3,0. cfg_pkt_len=0 gives 1-beat packets with tlast=1.
- Unlimited mode, cfg_stop mid-packet (beat 2 of 4): beats 3 and 4 still sent, then tvalid=0, done pulse, busy=0. A stop during GAP ends immediately with done.
- Reset asserted during SEND with tvalid=1: next cycle tvalid, busy and pkts_sent are 0 and state is IDLE. A new start restarts seq at 0.

Source files
------------

// File: rtl/axis_packet_gen.sv
// axis_packet_gen
//   AXI-Stream traffic generator for one mesh ingress port. Emits packets of
//   programmable length, destination pattern and inter-packet gap. Every beat
//   carries a self-describing payload {SRC_ID, seq, beat_idx}, so downstream
//   checkers can verify ordering and integrity.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   cfg_start          pulse: latch cfg_* and begin generation (ignored while busy)
//   cfg_stop           pulse: finish the current packet, then stop
//   cfg_mode           dest mode: 0 fixed, 1 round-robin, 2 LFSR, 3 round-robin skipping SRC_ID
//   cfg_fixed_dest     destination used in mode 0
//   cfg_pkt_len        beats per packet (0 behaves as 1)
//   cfg_num_pkts       packets to send (0 = unlimited)
//   cfg_gap            idle cycles between packets
//   busy, done         generator active / one-cycle completion pulse
//   pkts_sent          packets fully accepted since the last start
//   axis_out_*         AXI-Stream master (all outputs registered)
module axis_packet_gen #(
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 4,
  parameter int NUM_DESTS   = 4,
  parameter int SRC_ID      = 0,
  parameter int LEN_WIDTH   = 8,
  parameter int SEQ_WIDTH   = 16,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [1:0]             cfg_mode,
  input  logic [TDEST_WIDTH-1:0] cfg_fixed_dest,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic [SEQ_WIDTH-1:0]   cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  output logic                   busy,
  output logic                   done,
  output logic [SEQ_WIDTH-1:0]   pkts_sent,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  localparam int BEAT_WIDTH = TDATA_WIDTH - TDEST_WIDTH - SEQ_WIDTH;
  localparam logic [TDEST_WIDTH-1:0] SRC_DEST  = TDEST_WIDTH'(SRC_ID);
  localparam logic [TDEST_WIDTH-1:0] LAST_DEST = TDEST_WIDTH'(NUM_DESTS - 1);
  localparam logic [15:0]            LFSR_SEED = 16'hACE1;
  localparam logic [15:0]            NUM_DESTS_16 = 16'(NUM_DESTS);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                 state_q, state_d;
  logic                   tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [SEQ_WIDTH-1:0]   pkts_sent_q, pkts_sent_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [TDEST_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                   stop_pending_q, stop_pending_d;
  logic [LEN_WIDTH-1:0]   beat_idx_q, beat_idx_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;

  // Configuration captured at start
  logic [1:0]             mode_q, mode_d;
  logic [TDEST_WIDTH-1:0] fixed_dest_q, fixed_dest_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [SEQ_WIDTH-1:0]   num_q, num_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;

  // Per-packet destination selection
  logic [1:0]             mode_sel;
  logic [TDEST_WIDTH-1:0] fixed_sel, dest_pick, rr_pick;
  logic [LEN_WIDTH-1:0]   eff_len_in, len_sel;
  logic [15:0]            lfsr_pick, lfsr_mod;
  logic                   lfsr_fb;

  logic                   start_pkt, finish;
  logic [SEQ_WIDTH-1:0]   start_seq;

  function automatic logic [TDEST_WIDTH-1:0] rr_inc(input logic [TDEST_WIDTH-1:0] p);
    return (p >= LAST_DEST) ? '0 : p + TDEST_WIDTH'(1);
  endfunction

  // The first packet of a run uses the live cfg_* inputs (they are latched
  // in the same cycle); later packets use the captured copy.
  assign eff_len_in = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign mode_sel   = (state_q == IDLE) ? cfg_mode       : mode_q;
  assign fixed_sel  = (state_q == IDLE) ? cfg_fixed_dest : fixed_dest_q;
  assign len_sel    = (state_q == IDLE) ? eff_len_in     : len_q;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_mod = lfsr_q % NUM_DESTS_16;

  // Round-robin and LFSR modes use the current value for this packet and
  // advance for the next one, so the first packet after reset goes to dest 0
  // (round-robin) or SEED mod NUM_DESTS (LFSR).
  always_comb begin
    dest_pick = fixed_sel;
    rr_pick   = rr_ptr_q;
    lfsr_pick = lfsr_q;
    case (mode_sel)
      2'd0: dest_pick = fixed_sel;
      2'd1: begin
        dest_pick = rr_ptr_q;
        rr_pick   = rr_inc(rr_ptr_q);
      end
      2'd2: begin
        dest_pick = lfsr_mod[TDEST_WIDTH-1:0];
        lfsr_pick = {lfsr_fb, lfsr_q[15:1]};
      end
      default: begin
        if (NUM_DESTS == 1) begin
          dest_pick = SRC_DEST;
        end else if (rr_ptr_q == SRC_DEST) begin
          dest_pick = rr_inc(rr_ptr_q);
          rr_pick   = rr_inc(rr_inc(rr_ptr_q));
        end else begin
          dest_pick = rr_ptr_q;
          rr_pick   = rr_inc(rr_ptr_q);
        end
      end
    endcase
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch; blocking '=' is correct in
  // combinational logic, while the register block below uses '<=' only.
  always_comb begin
    state_d        = state_q;
    tvalid_d       = tvalid_q;
    tlast_d        = tlast_q;
    tdata_d        = tdata_q;
    tdest_d        = tdest_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    pkts_sent_d    = pkts_sent_q;
    lfsr_d         = lfsr_q;
    rr_ptr_d       = rr_ptr_q;
    stop_pending_d = stop_pending_q;
    beat_idx_d     = beat_idx_q;
    gap_cnt_d      = gap_cnt_q;
    mode_d         = mode_q;
    fixed_dest_d   = fixed_dest_q;
    len_d          = len_q;
    num_d          = num_q;
    gap_d          = gap_q;
    start_pkt      = 1'b0;
    finish         = 1'b0;
    start_seq      = pkts_sent_q;

    case (state_q)
      IDLE: begin
        // A stop in the same cycle is dropped: stop_pending is cleared here.
        if (cfg_start) begin
          mode_d         = cfg_mode;
          fixed_dest_d   = cfg_fixed_dest;
          len_d          = eff_len_in;
          num_d          = cfg_num_pkts;
          gap_d          = cfg_gap;
          pkts_sent_d    = '0;
          stop_pending_d = 1'b0;
          busy_d         = 1'b1;
          start_seq      = '0;
          start_pkt      = 1'b1;
        end
      end
      SEND: begin
        if (cfg_stop) stop_pending_d = 1'b1;
        if (tvalid_q && axis_out_tready) begin
          if (tlast_q) begin
            pkts_sent_d = pkts_sent_q + SEQ_WIDTH'(1);
            if ((num_q != '0 && pkts_sent_d == num_q) || stop_pending_q || cfg_stop) begin
              finish = 1'b1;
            end else if (gap_q == '0) begin
              start_pkt = 1'b1;
              start_seq = pkts_sent_d;
            end else begin
              state_d   = GAP;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
              gap_cnt_d = gap_q - GAP_WIDTH'(1);
            end
          end else begin
            beat_idx_d = beat_idx_q + LEN_WIDTH'(1);
            tlast_d    = (beat_idx_d == len_q - LEN_WIDTH'(1));
            tdata_d    = {tdata_q[TDATA_WIDTH-1:BEAT_WIDTH], BEAT_WIDTH'(beat_idx_d)};
          end
        end
      end
      GAP: begin
        // gap_cnt counts down from cfg_gap-1, giving exactly cfg_gap idle cycles.
        if (stop_pending_q || cfg_stop) finish = 1'b1;
        else if (gap_cnt_q == '0)       start_pkt = 1'b1;
        else                            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase

    if (start_pkt) begin
      state_d    = SEND;
      tvalid_d   = 1'b1;
      beat_idx_d = '0;
      tlast_d    = (len_sel == LEN_WIDTH'(1));
      tdest_d    = dest_pick;
      rr_ptr_d   = rr_pick;
      lfsr_d     = lfsr_pick;
      tdata_d    = {SRC_DEST, start_seq, {BEAT_WIDTH{1'b0}}};
    end

    if (finish) begin
      state_d        = IDLE;
      tvalid_d       = 1'b0;
      tlast_d        = 1'b0;
      busy_d         = 1'b0;
      done_d         = 1'b1;
      stop_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      tdata_q        <= '0;
      tdest_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pkts_sent_q    <= '0;
      lfsr_q         <= LFSR_SEED;
      rr_ptr_q       <= '0;
      stop_pending_q <= 1'b0;
      beat_idx_q     <= '0;
      gap_cnt_q      <= '0;
      mode_q         <= '0;
      fixed_dest_q   <= '0;
      len_q          <= LEN_WIDTH'(1);
      num_q          <= '0;
      gap_q          <= '0;
    end else begin
      state_q        <= state_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      tdata_q        <= tdata_d;
      tdest_q        <= tdest_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pkts_sent_q    <= pkts_sent_d;
      lfsr_q         <= lfsr_d;
      rr_ptr_q       <= rr_ptr_d;
      stop_pending_q <= stop_pending_d;
      beat_idx_q     <= beat_idx_d;
      gap_cnt_q      <= gap_cnt_d;
      mode_q         <= mode_d;
      fixed_dest_q   <= fixed_dest_d;
      len_q          <= len_d;
      num_q          <= num_d;
      gap_q          <= gap_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pkts_sent       = pkts_sent_q;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tdest  = tdest_q;

endmodule
